// File: rtl/regfile_wb_arbiter_if.sv
// Register-file writeback arbiter bus: pipeline writeback, long-latency
// result handshake, register-file write port and interlock/status outputs.
interface regfile_wb_arbiter_if #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

    logic            wb_valid;
    logic [4:0]      wb_rd;
    logic [XLEN-1:0] wb_data;
    logic            ll_valid;
    logic            ll_ready;
    logic [4:0]      ll_rd;
    logic [XLEN-1:0] ll_data;
    logic            rf_we;
    logic [4:0]      rf_rd;
    logic [XLEN-1:0] rf_wdata;
    logic [31:0]     busy_mask;
    logic [CW-1:0]   fifo_count;
    logic            stall_req;

    // Pipeline / long-latency producers side
    modport master (
        output wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
        input  ll_ready, rf_we, rf_rd, rf_wdata, busy_mask, fifo_count, stall_req
    );

    // Arbiter side
    modport slave (
        input  wb_valid, wb_rd, wb_data, ll_valid, ll_rd, ll_data,
        output ll_ready, rf_we, rf_rd, rf_wdata, busy_mask, fifo_count, stall_req
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// Single writer for the register-file write port. Pipeline writebacks always
// win; long-latency results wait in a small FIFO and drain on idle cycles.
// WAW hazards are resolved by killing older queued entries for the same
// register, and busy_mask tracks registers with a live queued write.
// Optional feature macro: STARVE_GUARD_EN (head starvation guard, stall_req).
module regfile_wb_arbiter #(
    parameter int unsigned XLEN         = 32,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter int unsigned STARVE_LIMIT = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    regfile_wb_arbiter_if.slave  bus
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;

    // Elaboration-time parameter sanity
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0 || STARVE_LIMIT < 1) begin : g_bad_param
        $error("regfile_wb_arbiter: illegal FIFO_DEPTH or STARVE_LIMIT");
    end

    logic [4:0]        ent_rd   [FIFO_DEPTH];
    logic [XLEN-1:0]   ent_data [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] ent_live;
    logic [CW-1:0]     wr_ptr, rd_ptr;

    logic              ll_ready_q;
    logic              rf_we_q;
    logic [4:0]        rf_rd_q;
    logic [XLEN-1:0]   rf_wdata_q;
    logic [31:0]       busy_q;
    logic [CW-1:0]     count_q;

    logic [AW-1:0]     wr_idx, rd_idx;
    logic              empty, head_live;
    logic              wb_write, enq, enq_live, pop, ll_write;
    logic [CW-1:0]     wr_ptr_n, rd_ptr_n, count_n;
    logic [FIFO_DEPTH-1:0] live_n;
    logic [31:0]       busy_n;

    // Arbitration decode: who writes this cycle, what pops, what enqueues
    always_comb begin
        wr_idx    = wr_ptr[AW-1:0];
        rd_idx    = rd_ptr[AW-1:0];
        empty     = (wr_ptr == rd_ptr);
        head_live = !empty && ent_live[rd_idx];
        wb_write  = bus.wb_valid && (bus.wb_rd != 5'd0);
        enq       = bus.ll_valid && ll_ready_q && (bus.ll_rd != 5'd0);
        // Pipeline write to the same register in the same cycle is newer
        enq_live  = !(wb_write && (bus.wb_rd == bus.ll_rd));
        // Dead heads drain unconditionally; live heads only when the pipeline is idle
        pop       = !empty && (!ent_live[rd_idx] || !wb_write);
        ll_write  = pop && head_live;
        wr_ptr_n  = wr_ptr + CW'(enq);
        rd_ptr_n  = rd_ptr + CW'(pop);
        count_n   = wr_ptr_n - rd_ptr_n;
    end

    // Next liveness of every slot and the resulting exact busy mask
    always_comb begin
        live_n = ent_live;
        busy_n = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wb_write && (ent_rd[i] == bus.wb_rd)) live_n[i] = 1'b0;
            if (enq && (ent_rd[i] == bus.ll_rd))      live_n[i] = 1'b0;
        end
        if (pop) live_n[rd_idx] = 1'b0;
        if (enq) live_n[wr_idx] = enq_live;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (live_n[i]) begin
                if (enq && (AW'(i) == wr_idx)) busy_n[bus.ll_rd]  = 1'b1;
                else                           busy_n[ent_rd[i]] = 1'b1;
            end
        end
        busy_n[0] = 1'b0;
    end

    // FIFO control state, status flags and queued destination registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            ent_live   <= '0;
            ll_ready_q <= 1'b1;
            busy_q     <= '0;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) ent_rd[i] <= '0;
        end else begin
            wr_ptr     <= wr_ptr_n;
            rd_ptr     <= rd_ptr_n;
            ent_live   <= live_n;
            ll_ready_q <= (count_n != CW'(FIFO_DEPTH));
            busy_q     <= busy_n;
            count_q    <= count_n;
            if (enq) ent_rd[wr_idx] <= bus.ll_rd;
        end
    end

    // Queued result data; liveness is tracked separately so no reset needed
    always_ff @(posedge clk) begin
        if (enq) ent_data[wr_idx] <= bus.ll_data;
    end

    // Registered register-file write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rf_we_q    <= 1'b0;
            rf_rd_q    <= '0;
            rf_wdata_q <= '0;
        end else begin
            rf_we_q <= wb_write || ll_write;
            if (wb_write) begin
                rf_rd_q    <= bus.wb_rd;
                rf_wdata_q <= bus.wb_data;
            end else if (ll_write) begin
                rf_rd_q    <= ent_rd[rd_idx];
                rf_wdata_q <= ent_data[rd_idx];
            end
        end
    end

`ifdef STARVE_GUARD_EN
    localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

    logic [SW-1:0] starve_cnt;
    logic          stall_q;
    logic          blocked;

    assign blocked = head_live && wb_write;

    // Count cycles a live head is blocked; pulse stall_req at the limit
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else if (blocked) begin
            if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
                starve_cnt <= '0;
                stall_q    <= 1'b1;
            end else begin
                starve_cnt <= starve_cnt + SW'(1);
                stall_q    <= 1'b0;
            end
        end else begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end
    end

    // The pipeline must honour the stall; it still wins if it does not
    a_stall_honoured: assert property (@(posedge clk) disable iff (!rst_n) stall_q |-> !bus.wb_valid);

    assign bus.stall_req = stall_q;
`else
    assign bus.stall_req = 1'b0;
`endif

    assign bus.ll_ready   = ll_ready_q;
    assign bus.rf_we      = rf_we_q;
    assign bus.rf_rd      = rf_rd_q;
    assign bus.rf_wdata   = rf_wdata_q;
    assign bus.busy_mask  = busy_q;
    assign bus.fifo_count = count_q;
endmodule
